// File: rtl/holy_core_pkg.sv
// Shared types for the holy core memory subsystem.
//   cache_state_t : cache controller FSM states (IDLE means no bus request)
//   arb_state_t   : AXI arbiter states; the encoding doubles as the owner code
package holy_core_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE                = 3'd0,
    SENDING_WRITE_REQ   = 3'd1,
    SENDING_WRITE_DATA  = 3'd2,
    WAITING_WRITE_RES   = 3'd3,
    SENDING_READ_REQ    = 3'd4,
    RECEIVING_READ_DATA = 3'd5
  } cache_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = OWNER_NONE,
    GRANT_I  = OWNER_I,
    GRANT_D  = OWNER_D
  } arb_state_t;

endpackage

// File: rtl/axi_if.sv
// AXI bundle (AW, W, B, AR, R channels) shared by the caches and the arbiter.
//   master : drives aw*, w*, bready, ar*, rready
//   slave  : drives awready, wready, b*, arready, r* (except rready)
interface axi_if;
  import holy_core_pkg::*;

  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_DATA_W-1:0]   rdata;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/holy_axi_burst_checker.sv
// Burst-length checker for the shared AXI port.
//   clk, rst_n       : clock, async active-low reset
//   clr              : grant change; restarts both counters
//   r_beat / r_last  : accepted R beat and its rlast
//   w_beat / w_last  : accepted W beat and its wlast
//   axi_err          : sticky; set when a burst is not exactly BURST_LEN beats
module holy_axi_burst_checker #(
  parameter int unsigned BURST_LEN = 128,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic r_beat,
  input  logic r_last,
  input  logic w_beat,
  input  logic w_last,
  output logic axi_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_bad;
  logic             w_bad;

  // A beat is wrong if last comes early/late, or the final index passes without last.
  always_comb begin
    r_bad = r_beat && (r_last ? (r_cnt != LAST_IDX) : (r_cnt == LAST_IDX));
    w_bad = w_beat && (w_last ? (w_cnt != LAST_IDX) : (w_cnt == LAST_IDX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      w_cnt   <= '0;
      axi_err <= 1'b0;
    end else begin
      if (clr)
        r_cnt <= '0;
      else if (r_beat)
        r_cnt <= r_last ? '0 : r_cnt + CNT_W'(1);

      if (clr)
        w_cnt <= '0;
      else if (w_beat)
        w_cnt <= w_last ? '0 : w_cnt + CNT_W'(1);

      if (r_bad || w_bad)
        axi_err <= 1'b1;
    end
  end

endmodule

// File: rtl/holy_axi_arbiter.sv
// Arbitrates the I-cache and D-cache onto one external AXI port.
//   clk, rst_n     : clock, async active-low reset
//   i/d_cache_state: cache FSM states; != IDLE means requesting
//   s_icache/s_dcache : cache-facing AXI ports
//   m_axi          : shared external AXI port
//   owner          : 00 none, 01 I, 10 D
//   axi_err        : sticky burst-length error
// A grant is held for the whole cache transaction; ties alternate.
module holy_axi_arbiter
  import holy_core_pkg::*;
#(
  parameter int unsigned BURST_LEN = 128,
  parameter int unsigned CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  cache_state_t i_cache_state,
  input  cache_state_t d_cache_state,
  axi_if.slave         s_icache,
  axi_if.slave         s_dcache,
  axi_if.master        m_axi,
  output logic [1:0]   owner,
  output logic         axi_err
);

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;  // 1: most recent grant went to D
  logic       i_req, d_req;

  assign i_req = (i_cache_state != IDLE);
  assign d_req = (d_cache_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_req && (!d_req || last_d_q)) state_d = GRANT_I;
        else if (d_req)                    state_d = GRANT_D;
      end
      GRANT_I: if (!i_req) state_d = d_req ? GRANT_D : ARB_IDLE;
      GRANT_D: if (!d_req) state_d = i_req ? GRANT_I : ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
    if (state_d == GRANT_I) last_d_d = 1'b0;
    if (state_d == GRANT_D) last_d_d = 1'b1;
  end

  assign owner = state_q;

  always_comb begin
    m_axi.awaddr  = '0; m_axi.awlen  = '0; m_axi.awvalid = 1'b0;
    m_axi.wdata   = '0; m_axi.wstrb  = '0; m_axi.wlast   = 1'b0;
    m_axi.wvalid  = 1'b0; m_axi.bready = 1'b0;
    m_axi.araddr  = '0; m_axi.arlen  = '0; m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    s_icache.awready = 1'b0; s_icache.wready = 1'b0; s_icache.bvalid = 1'b0;
    s_icache.bresp   = '0;   s_icache.arready = 1'b0; s_icache.rvalid = 1'b0;
    s_icache.rdata   = '0;   s_icache.rlast  = 1'b0;
    s_dcache.awready = 1'b0; s_dcache.wready = 1'b0; s_dcache.bvalid = 1'b0;
    s_dcache.bresp   = '0;   s_dcache.arready = 1'b0; s_dcache.rvalid = 1'b0;
    s_dcache.rdata   = '0;   s_dcache.rlast  = 1'b0;
    case (state_q)
      GRANT_I: begin
        m_axi.awaddr  = s_icache.awaddr;  m_axi.awlen   = s_icache.awlen;
        m_axi.awvalid = s_icache.awvalid; m_axi.wdata   = s_icache.wdata;
        m_axi.wstrb   = s_icache.wstrb;   m_axi.wlast   = s_icache.wlast;
        m_axi.wvalid  = s_icache.wvalid;  m_axi.bready  = s_icache.bready;
        m_axi.araddr  = s_icache.araddr;  m_axi.arlen   = s_icache.arlen;
        m_axi.arvalid = s_icache.arvalid; m_axi.rready  = s_icache.rready;
        s_icache.awready = m_axi.awready; s_icache.wready  = m_axi.wready;
        s_icache.bvalid  = m_axi.bvalid;  s_icache.bresp   = m_axi.bresp;
        s_icache.arready = m_axi.arready; s_icache.rvalid  = m_axi.rvalid;
        s_icache.rdata   = m_axi.rdata;   s_icache.rlast   = m_axi.rlast;
      end
      GRANT_D: begin
        m_axi.awaddr  = s_dcache.awaddr;  m_axi.awlen   = s_dcache.awlen;
        m_axi.awvalid = s_dcache.awvalid; m_axi.wdata   = s_dcache.wdata;
        m_axi.wstrb   = s_dcache.wstrb;   m_axi.wlast   = s_dcache.wlast;
        m_axi.wvalid  = s_dcache.wvalid;  m_axi.bready  = s_dcache.bready;
        m_axi.araddr  = s_dcache.araddr;  m_axi.arlen   = s_dcache.arlen;
        m_axi.arvalid = s_dcache.arvalid; m_axi.rready  = s_dcache.rready;
        s_dcache.awready = m_axi.awready; s_dcache.wready  = m_axi.wready;
        s_dcache.bvalid  = m_axi.bvalid;  s_dcache.bresp   = m_axi.bresp;
        s_dcache.arready = m_axi.arready; s_dcache.rvalid  = m_axi.rvalid;
        s_dcache.rdata   = m_axi.rdata;   s_dcache.rlast   = m_axi.rlast;
      end
      default: ;
    endcase
  end

  holy_axi_burst_checker #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .r_beat  (m_axi.rvalid & m_axi.rready),
    .r_last  (m_axi.rlast),
    .w_beat  (m_axi.wvalid & m_axi.wready),
    .w_last  (m_axi.wlast),
    .axi_err (axi_err)
  );

endmodule

// File: doc/holy_axi_arbiter.md
HOLY_AXI_ARBITER -- requirements
Module: holy_axi_arbiter

Interface
- REQ-001 SHALL have parameter BURST_LEN, default 128, meaning the beats per burst expected from each cache.
- REQ-002 SHALL have parameter CNT_W, default 8, meaning the beat counter width; CNT_W SHALL hold BURST_LEN.
- REQ-003 SHALL have port clk  input  1  single clock for all logic.
- REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
- REQ-005 SHALL have port i_cache_state  input  cache_state_t  instruction cache FSM state.
- REQ-006 SHALL have port d_cache_state  input  cache_state_t  data cache FSM state.
- REQ-007 SHALL have port s_icache  axi_if.slave  bundle  AXI port driven by the instruction cache.
- REQ-008 SHALL have port s_dcache  axi_if.slave  bundle  AXI port driven by the data cache.
- REQ-009 SHALL have port m_axi  axi_if.master  bundle  shared external AXI port.
- REQ-010 SHALL have port owner  output  2  current grant: 00 none, 01 I, 10 D.
- REQ-011 SHALL have port axi_err  output  1  sticky burst-length protocol error flag.

Function
- REQ-012 SHALL implement the FSM states ARB_IDLE, GRANT_I and GRANT_D; owner SHALL encode the state.
- REQ-013 SHALL treat a cache as requesting when its cache_state != IDLE.
- REQ-014 In ARB_IDLE with one requester, SHALL enter that requester's GRANT state on the next clk edge, giving one cycle of grant latency.
- REQ-015 In ARB_IDLE with both requesting, SHALL grant the requester that did not receive the last grant; after reset the last grant SHALL be D, so I wins first.
- REQ-016 In GRANT_x, SHALL hold the grant while x's cache_state != IDLE, so a dirty write-back followed by a refill is never interleaved.
- REQ-017 In GRANT_x with x's cache_state == IDLE: if the other cache is requesting, SHALL move directly to its GRANT state; otherwise SHALL return to ARB_IDLE.
- REQ-018 While owner is I (or D), SHALL route all master-side signals of s_icache (or s_dcache) combinationally to m_axi: aw*, w*, bready, ar*, rready.
- REQ-019 While owner is I (or D), SHALL route all slave-side signals of m_axi back to the owner: awready, wready, bvalid, bresp, arready, rvalid, rdata, rlast.
- REQ-020 SHALL drive awready, wready, bvalid, arready and rvalid to 0 on the non-owner port.
- REQ-021 In ARB_IDLE, SHALL drive m_axi awvalid, wvalid, arvalid, bready and rready to 0.
- REQ-022 SHALL count accepted R beats (rvalid & rready) and accepted W beats (wvalid & wready) on m_axi in separate CNT_W counters.
- REQ-023 SHALL clear each counter on its last beat and on every grant change.
- REQ-024 If rlast (or wlast) is accepted with the count != BURST_LEN-1, or count reaches BURST_LEN-1 without last, SHALL set axi_err=1 until reset.
- REQ-025 Data paths SHALL add no registers; the latency from owner to slave and back SHALL be 0 cycles.

Reset
- REQ-026 Assertion of rst_n=0 SHALL immediately force ARB_IDLE, owner=00, axi_err=0, counters=0 and last-grant=D, including mid-burst.
- REQ-027 During reset, all m_axi valid/ready outputs and all slave-side valid/ready outputs SHALL be 0.

Structure
- REQ-028 arb_state_t and the owner encodings SHALL reside in holy_core_pkg; cache_state_t SHALL be reused from holy_core_pkg.
- REQ-029 The burst-length checker (both counters plus the axi_err logic) SHALL be the sub-module holy_axi_burst_checker.
- REQ-030 The FSM and muxes SHALL remain in the top module.

Verification
- REQ-031 I-cache enters SENDING_READ_REQ alone -> owner=01 one cycle later; 128 R beats reach s_icache; returning to IDLE -> owner=00, axi_err=0.
- REQ-032 Both caches request in the same cycle after reset -> I is granted first; D is granted directly after I returns to IDLE, with no ARB_IDLE cycle.
- REQ-033 D performs a dirty write-back (128 W beats, bresp=00) then a refill while I requests -> owner stays 10 throughout; I's arready is held 0 until D is IDLE.
- REQ-034 Slave asserts rlast on beat 100 -> axi_err=1 and stays 1 through later bursts until rst_n=0.
- REQ-035 Assert rst_n=0 at W beat 50 -> owner=00 and m_axi wvalid=0 in the same cycle; after release, a new request is granted normally.
